fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the 7-bit-address, 8-bit-data instruction ROM (combinational read).

---
 rtl/proc_pkg.sv | 17 +
 rtl/fetch_pc.sv | 46 ++++
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM states, datapath widths and opcodes.
package proc_pkg;

   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned INSTR_W = 8;

   localparam logic [INSTR_W-1:0] OP_HALT  = 8'hFF;
   localparam logic [ADDR_W-1:0]  START_PC = 7'h00;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED,
      ERROR
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with load, hold and increment; exposes increment carry-out
// when FETCH_PC_WRAP_ERR_EN is defined.
module fetch_pc
   import proc_pkg::*;
#(
   parameter int unsigned          AW         = ADDR_W,
   parameter logic [ADDR_W-1:0]    START_ADDR = START_PC
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          load_i,
   input  logic [AW-1:0] load_addr_i,
   input  logic          inc_i,
`ifdef FETCH_PC_WRAP_ERR_EN
   output logic          carry_c_o,
`endif
   output logic [AW-1:0] pc_o
);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;

   // Load wins over increment; neither means hold.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_addr_i;
      end else if (inc_i) begin
         pc_d = pc_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q <= AW'(START_ADDR);
      end else begin
         pc_q <= pc_d;
      end
   end

`ifdef FETCH_PC_WRAP_ERR_EN
   assign carry_c_o = &pc_q;
`endif
   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives ROM address, registers fetched byte, handles
// stall, branch squash and halt. FETCH_PC_WRAP_ERR_EN enables the PC-wrap ERROR state.
module fetch_ctrl
   import proc_pkg::*;
#(
   parameter int unsigned        AW          = ADDR_W,
   parameter int unsigned        DW          = INSTR_W,
   parameter logic [ADDR_W-1:0]  START_ADDR  = START_PC,
   parameter logic [INSTR_W-1:0] HALT_OPCODE = OP_HALT
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic          stall_i,
   input  logic          branch_en_i,
   input  logic [AW-1:0] branch_target_i,
   output logic [AW-1:0] rom_addr_o,
   input  logic [DW-1:0] rom_data_i,
   output logic [DW-1:0] instr_o,
   output logic [AW-1:0] instr_pc_o,
   output logic          instr_valid_o,
   output logic          done_o,
   output logic          err_o
);

   fetch_state_t  state_q, state_d;
   logic [DW-1:0] instr_q, instr_d;
   logic [AW-1:0] instr_pc_q, instr_pc_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic [AW-1:0] pc;
   logic          pc_load;
   logic [AW-1:0] pc_load_addr;
   logic          pc_inc;
`ifdef FETCH_PC_WRAP_ERR_EN
   logic          err_q, err_d;
   logic          pc_carry;
`endif

   fetch_pc #(
      .AW         (AW),
      .START_ADDR (START_ADDR)
   ) u_pc (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (pc_load),
      .load_addr_i (pc_load_addr),
      .inc_i       (pc_inc),
`ifdef FETCH_PC_WRAP_ERR_EN
      .carry_c_o   (pc_carry),
`endif
      .pc_o        (pc)
   );

   // Next-state, PC control and instruction-register updates.
   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
      valid_d      = valid_q;
      done_d       = done_q;
      pc_load      = 1'b0;
      pc_load_addr = AW'(START_ADDR);
      pc_inc       = 1'b0;
`ifdef FETCH_PC_WRAP_ERR_EN
      err_d        = err_q;
`endif
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (branch_en_i) begin
               // Byte at the old PC is squashed without a halt check.
               pc_load      = 1'b1;
               pc_load_addr = branch_target_i;
               valid_d      = 1'b0;
            end else if (!stall_i) begin
               instr_d    = rom_data_i;
               instr_pc_d = pc;
               valid_d    = 1'b1;
               if (rom_data_i == HALT_OPCODE) begin
                  state_d = HALTED;
               end else begin
                  pc_inc = 1'b1;
`ifdef FETCH_PC_WRAP_ERR_EN
                  if (pc_carry) begin
                     state_d = ERROR;
                  end
`endif
               end
            end
         end
         HALTED: begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            if (start_i) begin
               pc_load = 1'b1;
               done_d  = 1'b0;
               state_d = RUN;
            end
         end
         ERROR: begin
            valid_d = 1'b0;
`ifdef FETCH_PC_WRAP_ERR_EN
            err_d   = 1'b1;
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
`ifdef FETCH_PC_WRAP_ERR_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
`ifdef FETCH_PC_WRAP_ERR_EN
         err_q      <= err_d;
`endif
      end
   end

   assign rom_addr_o    = pc;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign instr_valid_o = valid_q;
   assign done_o        = done_q;
`ifdef FETCH_PC_WRAP_ERR_EN
   assign err_o         = err_q;
`else
   assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: ROM model plus scoreboard of expected fetches.
`timescale 1ns/1ps
module tb_fetch_ctrl;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic       stall_i;
   logic       branch_en_i;
   logic [6:0] branch_target_i;
   logic [6:0] rom_addr_o;
   logic [7:0] rom_data_i;
   logic [7:0] instr_o;
   logic [6:0] instr_pc_o;
   logic       instr_valid_o;
   logic       done_o;
   logic       err_o;

   typedef struct packed {
      logic [6:0] pc;
      logic [7:0] instr;
   } exp_t;

   logic [7:0] rom [0:127];
   exp_t       sb [$];
   exp_t       got;
   int         n_cmp = 0;
   int         n_bad = 0;

   fetch_ctrl dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .start_i         (start_i),
      .stall_i         (stall_i),
      .branch_en_i     (branch_en_i),
      .branch_target_i (branch_target_i),
      .rom_addr_o      (rom_addr_o),
      .rom_data_i      (rom_data_i),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .instr_valid_o   (instr_valid_o),
      .done_o          (done_o),
      .err_o           (err_o)
   );

   always #5 clk_i = ~clk_i;
   assign rom_data_i = rom[rom_addr_o];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic void push_fetch(input logic [6:0] pc);
      sb.push_back('{pc: pc, instr: rom[pc]});
   endfunction

   task automatic test_reset();
      reset_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
      branch_en_i = 1'b0; branch_target_i = 7'h00;
      #3;
      n_cmp++;
      if ({instr_valid_o, done_o, err_o, instr_o, instr_pc_o, rom_addr_o} !== 25'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b d=%b e=%b i=%h ipc=%h a=%h, want all 0",
                  instr_valid_o, done_o, err_o, instr_o, instr_pc_o, rom_addr_o);
      end
      tick(); tick();
      reset_i = 1'b0;
      tick(); tick();
      n_cmp++;
      if (instr_valid_o !== 1'b0 || rom_addr_o !== 7'h00) begin
         n_bad++;
         $display("FAIL idle_no_fetch: got v=%b a=%h, want v=0 a=00", instr_valid_o, rom_addr_o);
      end
   endtask

   task automatic test_basic_halt();
      start_i = 1'b1; tick(); start_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b0 || rom_addr_o !== 7'h00) begin
         n_bad++;
         $display("FAIL start_latency: got v=%b a=%h, want v=0 a=00", instr_valid_o, rom_addr_o);
      end
      for (int i = 0; i < 5; i++) begin
         push_fetch(7'(i));
         tick();
         n_cmp++;
         if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL basic_issue: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
         end else begin
            got = sb.pop_front();
            if ({instr_pc_o, instr_o} !== got) begin
               n_bad++;
               $display("FAIL basic_data: got pc=%h i=%h, want pc=%h i=%h",
                        instr_pc_o, instr_o, got.pc, got.instr);
            end
         end
      end
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b0 || done_o !== 1'b1 || rom_addr_o !== 7'h04) begin
         n_bad++;
         $display("FAIL halted: got v=%b d=%b a=%h, want v=0 d=1 a=04",
                  instr_valid_o, done_o, rom_addr_o);
      end
      branch_en_i = 1'b1; branch_target_i = 7'h20;
      tick();
      branch_en_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b0 || done_o !== 1'b1 || rom_addr_o !== 7'h04) begin
         n_bad++;
         $display("FAIL halted_ignores_branch: got v=%b d=%b a=%h, want v=0 d=1 a=04",
                  instr_valid_o, done_o, rom_addr_o);
      end
   endtask

   task automatic test_stall();
      start_i = 1'b1; tick(); start_i = 1'b0;
      n_cmp++;
      if (done_o !== 1'b0 || instr_valid_o !== 1'b0 || rom_addr_o !== 7'h00) begin
         n_bad++;
         $display("FAIL restart: got d=%b v=%b a=%h, want d=0 v=0 a=00",
                  done_o, instr_valid_o, rom_addr_o);
      end
      for (int i = 0; i < 2; i++) begin
         push_fetch(7'(i));
         tick();
         n_cmp++;
         if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL restart_issue: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
         end else begin
            got = sb.pop_front();
            if ({instr_pc_o, instr_o} !== got) begin
               n_bad++;
               $display("FAIL restart_data: got pc=%h i=%h, want pc=%h i=%h",
                        instr_pc_o, instr_o, got.pc, got.instr);
            end
         end
      end
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (instr_o !== 8'h11 || instr_pc_o !== 7'h01 || instr_valid_o !== 1'b1 ||
             rom_addr_o !== 7'h02) begin
            n_bad++;
            $display("FAIL stall_hold: got i=%h ipc=%h v=%b a=%h, want i=11 ipc=01 v=1 a=02",
                     instr_o, instr_pc_o, instr_valid_o, rom_addr_o);
         end
      end
      stall_i = 1'b0;
      push_fetch(7'h02);
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
         n_bad++;
         $display("FAIL stall_release: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
      end else begin
         got = sb.pop_front();
         if ({instr_pc_o, instr_o} !== got) begin
            n_bad++;
            $display("FAIL stall_release_data: got pc=%h i=%h, want pc=%h i=%h",
                     instr_pc_o, instr_o, got.pc, got.instr);
         end
      end
   endtask

   task automatic test_branch();
      n_cmp++;
      if (rom_addr_o !== 7'h03) begin
         n_bad++;
         $display("FAIL branch_pre: got a=%h, want a=03", rom_addr_o);
      end
      branch_en_i = 1'b1; branch_target_i = 7'h20;
      tick();
      branch_en_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b0 || rom_addr_o !== 7'h20) begin
         n_bad++;
         $display("FAIL branch_bubble: got v=%b a=%h, want v=0 a=20", instr_valid_o, rom_addr_o);
      end
      for (int i = 0; i < 2; i++) begin
         push_fetch(7'(32 + i));
         tick();
         n_cmp++;
         if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL branch_issue: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
         end else begin
            got = sb.pop_front();
            if ({instr_pc_o, instr_o} !== got) begin
               n_bad++;
               $display("FAIL branch_data: got pc=%h i=%h, want pc=%h i=%h",
                        instr_pc_o, instr_o, got.pc, got.instr);
            end
         end
      end
   endtask

   task automatic test_branch_stall();
      stall_i = 1'b1; branch_en_i = 1'b1; branch_target_i = 7'h05;
      tick();
      stall_i = 1'b0; branch_en_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b0 || rom_addr_o !== 7'h05) begin
         n_bad++;
         $display("FAIL branch_over_stall: got v=%b a=%h, want v=0 a=05", instr_valid_o, rom_addr_o);
      end
      push_fetch(7'h05);
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
         n_bad++;
         $display("FAIL branch_stall_issue: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
      end else begin
         got = sb.pop_front();
         if ({instr_pc_o, instr_o} !== got) begin
            n_bad++;
            $display("FAIL branch_stall_data: got pc=%h i=%h, want pc=%h i=%h",
                     instr_pc_o, instr_o, got.pc, got.instr);
         end
      end
   endtask

   task automatic test_reset_mid();
      branch_en_i = 1'b1; branch_target_i = 7'h02;
      tick();
      branch_en_i = 1'b0;
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || instr_o !== 8'h12 || rom_addr_o !== 7'h03) begin
         n_bad++;
         $display("FAIL reset_mid_pre: got v=%b i=%h a=%h, want v=1 i=12 a=03",
                  instr_valid_o, instr_o, rom_addr_o);
      end
      #2 reset_i = 1'b1;
      #1;
      n_cmp++;
      if ({instr_valid_o, done_o, err_o, instr_o, instr_pc_o, rom_addr_o} !== 25'd0) begin
         n_bad++;
         $display("FAIL reset_async: got v=%b d=%b e=%b i=%h ipc=%h a=%h, want all 0",
                  instr_valid_o, done_o, err_o, instr_o, instr_pc_o, rom_addr_o);
      end
      tick();
      reset_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (instr_valid_o !== 1'b0 || rom_addr_o !== 7'h00) begin
            n_bad++;
            $display("FAIL reset_idle: got v=%b a=%h, want v=0 a=00", instr_valid_o, rom_addr_o);
         end
      end
      start_i = 1'b1; tick(); start_i = 1'b0;
      push_fetch(7'h00);
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
         n_bad++;
         $display("FAIL reset_restart: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
      end else begin
         got = sb.pop_front();
         if ({instr_pc_o, instr_o} !== got) begin
            n_bad++;
            $display("FAIL reset_restart_data: got pc=%h i=%h, want pc=%h i=%h",
                     instr_pc_o, instr_o, got.pc, got.instr);
         end
      end
   endtask

   task automatic test_wrap();
      branch_en_i = 1'b1; branch_target_i = 7'h7F;
      tick();
      branch_en_i = 1'b0;
      push_fetch(7'h7F);
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
         n_bad++;
         $display("FAIL wrap_issue: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
      end else begin
         got = sb.pop_front();
         if ({instr_pc_o, instr_o} !== got) begin
            n_bad++;
            $display("FAIL wrap_data: got pc=%h i=%h, want pc=%h i=%h",
                     instr_pc_o, instr_o, got.pc, got.instr);
         end
      end
`ifdef FETCH_PC_WRAP_ERR_EN
      tick();
      n_cmp++;
      if (err_o !== 1'b1 || instr_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_err: got e=%b v=%b, want e=1 v=0", err_o, instr_valid_o);
      end
      start_i = 1'b1; tick(); tick(); start_i = 1'b0;
      n_cmp++;
      if (err_o !== 1'b1 || instr_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL err_sticky: got e=%b v=%b, want e=1 v=0", err_o, instr_valid_o);
      end
`else
      start_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         push_fetch(7'(i));
         tick();
         n_cmp++;
         if (instr_valid_o !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL wrap_zero_issue: got v=%b queued=%0d, want v=1", instr_valid_o, sb.size());
         end else begin
            got = sb.pop_front();
            if ({instr_pc_o, instr_o} !== got) begin
               n_bad++;
               $display("FAIL wrap_zero_data: got pc=%h i=%h, want pc=%h i=%h",
                        instr_pc_o, instr_o, got.pc, got.instr);
            end
         end
      end
      start_i = 1'b0;
      n_cmp++;
      if (err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_no_err: got e=%b, want e=0", err_o);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 8'(i) ^ 8'h3C;
      rom[0] = 8'h10; rom[1] = 8'h11; rom[2] = 8'h12; rom[3] = 8'h13; rom[4] = 8'hFF;
      rom[5] = 8'h25; rom[32] = 8'h55; rom[33] = 8'h56; rom[127] = 8'h77;

      test_reset();
      test_basic_halt();
      test_stall();
      test_branch();
      test_branch_stall();
      test_reset_mid();
      test_wrap();

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
